// File: rtl/pc_trace_checker_pkg.sv
// Shared types for the PC trace checker: checker states, the trace entry layout
// and the entry comparison used by the run logic.
package pc_trace_checker_pkg;

    localparam int ADDR_LEN  = 32;
    localparam int INSTR_LEN = 32;

    typedef enum logic [1:0] {
        CHK_IDLE = 2'd0,
        CHK_RUN  = 2'd1,
        CHK_PASS = 2'd2,
        CHK_FAIL = 2'd3
    } chk_state_e;

    // One expected fetch: the pc and the instruction word seen at that pc.
    typedef struct packed {
        logic [ADDR_LEN-1:0]  pc;
        logic [INSTR_LEN-1:0] inst;
    } trace_entry_t;

    // An observation matches an entry only when both pc and inst agree.
    function automatic logic entry_match(
        input trace_entry_t         e,
        input logic [ADDR_LEN-1:0]  obs_pc,
        input logic [INSTR_LEN-1:0] obs_inst
    );
        return (e.pc == obs_pc) && (e.inst == obs_inst);
    endfunction

endpackage

// File: rtl/pc_trace_checker_trace_mem.sv
// Expected-trace storage: synchronous write, asynchronous read so the checker
// can compare against the current index on the same edge without a bubble.
// Contents have no reset so a trace survives a checker reset.
module pc_trace_checker_trace_mem
    import pc_trace_checker_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         wr_en,
    input  logic [IW-1:0] wr_idx,
    input  trace_entry_t wr_data,
    input  logic [IW-1:0] rd_idx,
    output trace_entry_t rd_data
);

    trace_entry_t mem_q [DEPTH];

    // Entry write; only the checker decides when a write is allowed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/pc_trace_checker.sv
// Compares the pc/inst stream of a CPU against a preloaded expected trace and
// produces a registered verdict: pass, fail by mismatch, or fail by pc hang.
module pc_trace_checker
    import pc_trace_checker_pkg::*;
#(
    parameter int DEPTH        = 64,
    parameter int HANG_LIMIT   = 4,
    parameter bit STOP_ON_FAIL = 1'b1,
    localparam int IW = $clog2(DEPTH),
    localparam int CW = IW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_LEN-1:0]  pc,
    input  logic [INSTR_LEN-1:0] inst,
    input  logic                 ld_en,
    input  logic [IW-1:0]        ld_idx,
    input  logic [ADDR_LEN-1:0]  ld_pc,
    input  logic [INSTR_LEN-1:0] ld_inst,
    input  logic [CW-1:0]        trace_len,
    input  logic                 start,
    output logic                 done,
    output logic                 pass,
    output logic                 hang,
    output logic [CW-1:0]        mismatch_cnt,
    output logic [IW-1:0]        first_fail,
    output logic [CW-1:0]        chk_idx
);

    localparam int SW = $clog2(HANG_LIMIT + 1);
    localparam logic [SW-1:0] HANG_C  = SW'(HANG_LIMIT);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    chk_state_e          state_q, state_d;
    logic [CW-1:0]       chk_idx_q, chk_idx_d;
    logic [CW-1:0]       len_q, len_d;
    logic [CW-1:0]       mismatch_cnt_q, mismatch_cnt_d;
    logic [IW-1:0]       first_fail_q, first_fail_d;
    logic [ADDR_LEN-1:0] pc_q, pc_d;
    logic [SW-1:0]       stall_q, stall_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                hang_q, hang_d;

    logic          mem_we;
    trace_entry_t  wr_entry;
    trace_entry_t  rd_entry;
    logic          entry_ok;
    logic          len_ok;
    logic [CW-1:0] cmp_len;
    logic          last_cmp;
    logic [CW-1:0] mis_cnt_inc;
    logic [SW-1:0] stall_nxt;
    logic          hang_hit;
    logic          step;

    assign wr_entry = '{pc: ld_pc, inst: ld_inst};

    pc_trace_checker_trace_mem #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_trace_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_idx  (ld_idx),
        .wr_data (wr_entry),
        .rd_idx  (chk_idx_q[IW-1:0]),
        .rd_data (rd_entry)
    );

    // The start edge already compares entry 0, before len_q holds the length.
    assign cmp_len     = (state_q == CHK_IDLE) ? trace_len : len_q;
    assign entry_ok    = entry_match(rd_entry, pc, inst);
    assign len_ok      = (trace_len != '0) && (trace_len <= DEPTH_C);
    assign last_cmp    = (chk_idx_q == cmp_len - CW'(1));
    assign mis_cnt_inc = (!entry_ok && (mismatch_cnt_q != '1)) ? mismatch_cnt_q + CW'(1)
                                                               : mismatch_cnt_q;

    // Stall length of the pc; pc_q is only meaningful once a run is underway.
    always_comb begin
        stall_nxt = '0;
        if ((state_q == CHK_RUN) && (pc == pc_q)) begin
            stall_nxt = (stall_q == HANG_C) ? stall_q : stall_q + SW'(1);
        end
    end

    assign hang_hit = (state_q == CHK_RUN) && (stall_nxt >= HANG_C) && (chk_idx_q < len_q);

    // Next-state logic: loading and starting in IDLE, one comparison per edge in RUN.
    always_comb begin
        state_d        = state_q;
        chk_idx_d      = chk_idx_q;
        len_d          = len_q;
        mismatch_cnt_d = mismatch_cnt_q;
        first_fail_d   = first_fail_q;
        pc_d           = pc_q;
        stall_d        = stall_q;
        done_d         = done_q;
        pass_d         = pass_q;
        hang_d         = hang_q;
        mem_we         = 1'b0;
        step           = 1'b0;

        case (state_q)
            CHK_IDLE: begin
                if (ld_en) begin
                    // A load wins over a simultaneous start.
                    mem_we = 1'b1;
                end else if (start) begin
                    len_d = trace_len;
                    if (len_ok) begin
                        step = 1'b1;
                    end else begin
                        state_d = CHK_FAIL;
                        done_d  = 1'b1;
                    end
                end
            end
            CHK_RUN: begin
                step = 1'b1;
            end
            default: ;
        endcase

        if (step) begin
            chk_idx_d      = chk_idx_q + CW'(1);
            pc_d           = pc;
            stall_d        = stall_nxt;
            mismatch_cnt_d = mis_cnt_inc;
            if (!entry_ok && (mismatch_cnt_q == '0)) begin
                first_fail_d = chk_idx_q[IW-1:0];
            end

            if (hang_hit) begin
                state_d = CHK_FAIL;
                done_d  = 1'b1;
                hang_d  = 1'b1;
            end else if (!entry_ok && STOP_ON_FAIL) begin
                state_d = CHK_FAIL;
                done_d  = 1'b1;
            end else if (last_cmp) begin
                state_d = (mis_cnt_inc == '0) ? CHK_PASS : CHK_FAIL;
                pass_d  = (mis_cnt_inc == '0);
                done_d  = 1'b1;
            end else begin
                state_d = CHK_RUN;
            end
        end
    end

    // State and counter registers; the trace memory is deliberately not reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= CHK_IDLE;
            chk_idx_q      <= '0;
            len_q          <= '0;
            mismatch_cnt_q <= '0;
            first_fail_q   <= '0;
            pc_q           <= '0;
            stall_q        <= '0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            hang_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            chk_idx_q      <= chk_idx_d;
            len_q          <= len_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            first_fail_q   <= first_fail_d;
            pc_q           <= pc_d;
            stall_q        <= stall_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            hang_q         <= hang_d;
        end
    end

    assign done         = done_q;
    assign pass         = pass_q;
    assign hang         = hang_q;
    assign mismatch_cnt = mismatch_cnt_q;
    assign first_fail   = first_fail_q;
    assign chk_idx      = chk_idx_q;

endmodule

// File: tb/tb_pc_trace_checker.sv
// Bench for pc_trace_checker: two instances (stop-on-fail and count-all) share
// one stimulus stream; results are checked against a trace-walk model.
module tb_pc_trace_checker;

    localparam int DEPTH = 8;
    localparam int IW    = 3;
    localparam int CW    = 4;
    localparam int HANG  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   pc = '0, inst = '0, ld_pc = '0, ld_inst = '0;
    logic          ld_en = 1'b0, start = 1'b0;
    logic [IW-1:0] ld_idx = '0;
    logic [CW-1:0] trace_len = '0;

    logic          done_s, pass_s, hang_s, done_c, pass_c, hang_c;
    logic [CW-1:0] mc_s, idx_s, mc_c, idx_c;
    logic [IW-1:0] ff_s, ff_c;

    typedef struct packed {
        logic          done;
        logic          pass;
        logic          hang;
        logic [CW-1:0] mc;
        logic [IW-1:0] ff;
        logic [CW-1:0] idx;
        logic [7:0]    fin;
    } res_t;

    res_t obs [2];
    res_t expv [2];

    logic [31:0] tb_pc [DEPTH];
    logic [31:0] tb_inst [DEPTH];
    logic [31:0] act_pc [DEPTH];
    logic [31:0] act_inst [DEPTH];

    int tests_run = 0;
    int failed    = 0;

    always #5 clk = ~clk;

    pc_trace_checker #(.DEPTH(DEPTH), .HANG_LIMIT(HANG), .STOP_ON_FAIL(1'b1)) dut_s (
        .clk(clk), .rst(rst), .pc(pc), .inst(inst), .ld_en(ld_en), .ld_idx(ld_idx),
        .ld_pc(ld_pc), .ld_inst(ld_inst), .trace_len(trace_len), .start(start),
        .done(done_s), .pass(pass_s), .hang(hang_s), .mismatch_cnt(mc_s),
        .first_fail(ff_s), .chk_idx(idx_s)
    );

    pc_trace_checker #(.DEPTH(DEPTH), .HANG_LIMIT(HANG), .STOP_ON_FAIL(1'b0)) dut_c (
        .clk(clk), .rst(rst), .pc(pc), .inst(inst), .ld_en(ld_en), .ld_idx(ld_idx),
        .ld_pc(ld_pc), .ld_inst(ld_inst), .trace_len(trace_len), .start(start),
        .done(done_c), .pass(pass_c), .hang(hang_c), .mismatch_cnt(mc_c),
        .first_fail(ff_c), .chk_idx(idx_c)
    );

    function automatic string fmt(input res_t r);
        return $sformatf("done=%b pass=%b hang=%b mc=%0d ff=%0d idx=%0d fin=%0d",
                         r.done, r.pass, r.hang, r.mc, r.ff, r.idx, r.fin);
    endfunction

    // first_fail is only meaningful with a nonzero mismatch count.
    function automatic res_t read_dut(input int d, input logic [7:0] fin);
        res_t r;
        if (d == 0) begin
            r.done = done_s; r.pass = pass_s; r.hang = hang_s;
            r.mc = mc_s; r.ff = (mc_s != 0) ? ff_s : '0; r.idx = idx_s;
        end else begin
            r.done = done_c; r.pass = pass_c; r.hang = hang_c;
            r.mc = mc_c; r.ff = (mc_c != 0) ? ff_c : '0; r.idx = idx_c;
        end
        r.fin = fin;
        return r;
    endfunction

    // Walk the observed trace: count bad entries, track runs of repeated pc,
    // and stop at the first hang (or first bad entry when stopping on fail).
    task automatic model(input int len, input int d, input bit stop);
        int mc, ff, run, n;
        bit h, stopped, bad;
        res_t r;
        r = '0;
        r.done = 1'b1;
        if (len == 0 || len > DEPTH) begin
            r.fin = 8'd1;
        end else begin
            mc = 0; ff = 0; run = 0; n = 0; h = 0; stopped = 0;
            for (int i = 0; i < len && !stopped; i++) begin
                bad = (act_pc[i] != tb_pc[i]) || (act_inst[i] != tb_inst[i]);
                run = (i > 0 && act_pc[i] == act_pc[i-1]) ? run + 1 : 0;
                if (bad) begin
                    if (mc == 0) ff = i;
                    mc++;
                end
                n = i + 1;
                if (run >= HANG) begin
                    h = 1; stopped = 1;
                end else if (bad && stop) begin
                    stopped = 1;
                end
            end
            r.pass = !h && (mc == 0);
            r.hang = h;
            r.mc   = CW'(mc);
            r.ff   = (mc != 0) ? IW'(ff) : '0;
            r.idx  = CW'(n);
            r.fin  = 8'(n);
        end
        expv[d] = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; ld_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_entry(input int i, input logic [31:0] p, input logic [31:0] w);
        @(negedge clk);
        ld_en = 1'b1; ld_idx = IW'(i); ld_pc = p; ld_inst = w;
        tb_pc[i] = p; tb_inst[i] = w;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic act_from_mem();
        for (int i = 0; i < DEPTH; i++) begin
            act_pc[i] = tb_pc[i]; act_inst[i] = tb_inst[i];
        end
    endtask

    // Start a run and feed act_* for ncyc edges; with noise, stray loads and
    // starts are thrown in after the start edge. Records the edge where done rose.
    task automatic run_trace(input int len, input int ncyc, input bit noise);
        logic [7:0] fin [2];
        fin[0] = 0; fin[1] = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            start     = (k == 0) || (noise && $urandom_range(0, 3) == 0);
            trace_len = CW'(len);
            if (k < len && k < DEPTH) begin
                pc = act_pc[k]; inst = act_inst[k];
            end else begin
                pc = $urandom; inst = $urandom;
            end
            ld_en   = noise && (k > 0) && ($urandom_range(0, 1) == 1);
            ld_idx  = IW'($urandom);
            ld_pc   = $urandom;
            ld_inst = $urandom;
            @(posedge clk); #1;
            if (done_s && fin[0] == 0) fin[0] = 8'(k + 1);
            if (done_c && fin[1] == 0) fin[1] = 8'(k + 1);
        end
        @(negedge clk);
        start = 1'b0; ld_en = 1'b0;
        obs[0] = read_dut(0, fin[0]);
        obs[1] = read_dut(1, fin[1]);
        $display("[TB] run len=%0d edges=%0d | stop: %s | count: %s",
                 len, ncyc, fmt(obs[0]), fmt(obs[1]));
    endtask

    task automatic test_reset();
        do_reset();
        for (int d = 0; d < 2; d++) begin
            obs[d] = read_dut(d, 8'd0);
            tests_run++;
            if (obs[d] !== res_t'(0)) begin
                failed++;
                $display("FAIL reset dut%0d got %s want %s", d, fmt(obs[d]), fmt(res_t'(0)));
            end
        end
    endtask

    task automatic test_pass();
        do_reset();
        load_entry(0, 32'h0, 32'hA000_000A);
        load_entry(1, 32'h4, 32'hB000_000B);
        load_entry(2, 32'h8, 32'hC000_000C);
        load_entry(3, 32'hC, 32'hD000_000D);
        act_from_mem();
        run_trace(4, 7, 0);
        for (int d = 0; d < 2; d++) begin
            model(4, d, d == 0);
            tests_run++;
            if (obs[d] !== expv[d]) begin
                failed++;
                $display("FAIL pass4 dut%0d got %s want %s", d, fmt(obs[d]), fmt(expv[d]));
            end
        end
    endtask

    task automatic test_stop_on_fail();
        do_reset();
        act_from_mem();
        act_inst[2] = act_inst[2] ^ 32'h1;
        run_trace(4, 7, 0);
        for (int d = 0; d < 2; d++) begin
            model(4, d, d == 0);
            tests_run++;
            if (obs[d] !== expv[d]) begin
                failed++;
                $display("FAIL stop_on_fail dut%0d got %s want %s", d, fmt(obs[d]), fmt(expv[d]));
            end
        end
    endtask

    task automatic test_count_all();
        do_reset();
        act_from_mem();
        act_inst[1] = ~act_inst[1];
        act_pc[3]   = act_pc[3] + 32'h10;
        run_trace(4, 7, 0);
        for (int d = 0; d < 2; d++) begin
            model(4, d, d == 0);
            tests_run++;
            if (obs[d] !== expv[d]) begin
                failed++;
                $display("FAIL count_all dut%0d got %s want %s", d, fmt(obs[d]), fmt(expv[d]));
            end
        end
    endtask

    // pc spinning at 0x8 from entry 2 trips the hang; three repeats at the
    // tail stay one short of the limit and must still pass.
    task automatic test_hang();
        for (int v = 0; v < 2; v++) begin
            do_reset();
            for (int i = 0; i < DEPTH; i++) begin
                int hold;
                hold = (v == 0) ? 2 : 4;
                load_entry(i, 32'(4 * ((i < hold) ? i : hold)), 32'h1000 + 32'(i));
            end
            act_from_mem();
            run_trace(8, 11, 0);
            for (int d = 0; d < 2; d++) begin
                model(8, d, d == 0);
                tests_run++;
                if (obs[d] !== expv[d]) begin
                    failed++;
                    $display("FAIL hang_v%0d dut%0d got %s want %s", v, d, fmt(obs[d]), fmt(expv[d]));
                end
            end
        end
    endtask

    task automatic test_bad_len();
        int lens [2];
        lens[0] = 0; lens[1] = 9;
        for (int j = 0; j < 2; j++) begin
            do_reset();
            act_from_mem();
            run_trace(lens[j], 3, 0);
            for (int d = 0; d < 2; d++) begin
                model(lens[j], d, d == 0);
                tests_run++;
                if (obs[d] !== expv[d]) begin
                    failed++;
                    $display("FAIL bad_len%0d dut%0d got %s want %s", lens[j], d, fmt(obs[d]), fmt(expv[d]));
                end
            end
        end
        // start together with ld_en: the write lands, the start is dropped
        do_reset();
        @(negedge clk);
        ld_en = 1'b1; ld_idx = 3'd1; ld_pc = tb_pc[1]; ld_inst = 32'hB0B0_0001;
        start = 1'b1; trace_len = 4'd4; pc = tb_pc[0]; inst = tb_inst[0];
        tb_inst[1] = 32'hB0B0_0001;
        @(posedge clk); #1;
        @(negedge clk);
        ld_en = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            obs[d] = read_dut(d, 8'd0);
            tests_run++;
            if (obs[d] !== res_t'(0)) begin
                failed++;
                $display("FAIL start_with_ld dut%0d got %s want %s", d, fmt(obs[d]), fmt(res_t'(0)));
            end
        end
        act_from_mem();
        run_trace(4, 7, 0);
        for (int d = 0; d < 2; d++) begin
            model(4, d, d == 0);
            tests_run++;
            if (obs[d] !== expv[d]) begin
                failed++;
                $display("FAIL written_entry dut%0d got %s want %s", d, fmt(obs[d]), fmt(expv[d]));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        res_t mid;
        mid = '0;
        mid.idx = 4'd2;
        do_reset();
        act_from_mem();
        run_trace(4, 2, 0);
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (obs[d] !== mid) begin
                failed++;
                $display("FAIL mid_run dut%0d got %s want %s", d, fmt(obs[d]), fmt(mid));
            end
        end
        do_reset();
        for (int d = 0; d < 2; d++) begin
            obs[d] = read_dut(d, 8'd0);
            tests_run++;
            if (obs[d] !== res_t'(0)) begin
                failed++;
                $display("FAIL mid_reset dut%0d got %s want %s", d, fmt(obs[d]), fmt(res_t'(0)));
            end
        end
        run_trace(4, 7, 0);
        for (int d = 0; d < 2; d++) begin
            model(4, d, d == 0);
            tests_run++;
            if (obs[d] !== expv[d]) begin
                failed++;
                $display("FAIL rerun dut%0d got %s want %s", d, fmt(obs[d]), fmt(expv[d]));
            end
        end
    endtask

    // Random traces with loops (repeated pcs), sporadic corruption, odd lengths
    // and stray load/start pulses during the run.
    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int len, rep;
            do_reset();
            rep = $urandom_range(0, 3);
            for (int i = 0; i < DEPTH; i++) begin
                logic [31:0] p;
                p = (i > 0 && $urandom_range(0, 3) < rep) ? tb_pc[i-1] : $urandom;
                load_entry(i, p, $urandom);
            end
            act_from_mem();
            for (int i = 0; i < DEPTH; i++) begin
                if ($urandom_range(0, 5) == 0) act_inst[i] = act_inst[i] ^ (32'h1 << $urandom_range(0, 31));
                if ($urandom_range(0, 11) == 0) act_pc[i] = $urandom;
            end
            len = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 15))
                                              : $urandom_range(1, DEPTH);
            run_trace(len, ((len > DEPTH) ? 0 : len) + 3, 1);
            for (int d = 0; d < 2; d++) begin
                model(len, d, d == 0);
                tests_run++;
                if (obs[d] !== expv[d]) begin
                    failed++;
                    $display("FAIL random%0d dut%0d got %s want %s", it, d, fmt(obs[d]), fmt(expv[d]));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pass();
        test_stop_on_fail();
        test_count_all();
        test_hang();
        test_bad_len();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
